sdp_bram_pipe: RTL

Parametrised simple dual-port, single-clock block RAM for the PE array buffers.
- Adds per-column (byte) write enables and a configurable read latency of 1..4 cycles.
- Read-valid tracking travels with each read, so consumers need no external latency counters.
- Same-address read/write collisions resolve deterministically per a selectable mode and are flagged alongside the returned data.

---
 rtl/pe_mem_pkg.sv | 28 ++
 rtl/sdp_rd_stage.sv | 45 ++++
 rtl/sdp_bram_pipe.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pe_mem_pkg.sv
// Shared definitions for the PE array buffer memories.
//   - clog2          : ceiling log2, used for address widths
//   - RdwReadFirst / RdwWriteFirst : accepted RDW_MODE strings
//   - rdw_mode_e     : decoded collision mode used inside the RAM
//   - DefaultColWidth: default byte-enable column width
package pe_mem_pkg;

    localparam int unsigned DefaultColWidth = 8;

    localparam string RdwReadFirst  = "READ_FIRST";
    localparam string RdwWriteFirst = "WRITE_FIRST";

    typedef enum logic {
        RdwRead  = 1'b0,
        RdwWrite = 1'b1
    } rdw_mode_e;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdp_rd_stage.sv
// One read-pipeline register carrying {data, valid, collide}.
// Ports:
//   clka       : clock
//   rstb       : synchronous active-high reset, clears all three fields
//   data_i     : incoming read data, loaded only when valid_i is high
//   valid_i    : incoming read-valid, shifts every cycle
//   collide_i  : incoming collision flag, shifts every cycle
//   data_o / valid_o / collide_o : registered copies
module sdp_rd_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clka,
    input  logic             rstb,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             collide_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             collide_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             collide_q;

    always_ff @(posedge clka) begin
        if (rstb) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            collide_q <= 1'b0;
        end else begin
            valid_q   <= valid_i;
            collide_q <= collide_i;
            // Data holds between reads so the output keeps the last result.
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign collide_o = collide_q;

endmodule

// File: rtl/sdp_bram_pipe.sv
// Simple dual-port single-clock block RAM with byte (column) write enables,
// a 1..4 cycle read pipeline with travelling valid/collide flags, and a
// selectable same-address read/write collision policy.
// Ports:
//   clka          : clock, everything on the rising edge
//   rstb          : synchronous active-high reset of the read path only
//   wea           : per-column write enable (NB_COL bits)
//   addra / dina  : write address / write data
//   enb / addrb   : read request / read address
//   doutb         : read data, holds the last result between reads
//   doutb_valid   : one-cycle pulse per accepted read
//   doutb_collide : set with doutb_valid when that read hit a same-cycle write
module sdp_bram_pipe
    import pe_mem_pkg::*;
#(
    parameter int unsigned  RAM_WIDTH    = 32,
    parameter int unsigned  COL_WIDTH    = DefaultColWidth,
    parameter int unsigned  RAM_DEPTH    = 256,
    parameter int unsigned  READ_LATENCY = 2,
    parameter string        RDW_MODE     = RdwReadFirst,
    parameter string        INIT_FILE    = "",
    localparam int unsigned NB_COL       = RAM_WIDTH / COL_WIDTH,
    localparam int unsigned ADDR_W       = clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic [NB_COL-1:0]    wea,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 enb,
    input  logic [ADDR_W-1:0]    addrb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 doutb_valid,
    output logic                 doutb_collide
);

    localparam rdw_mode_e RdwMode = (RDW_MODE == RdwWriteFirst) ? RdwWrite : RdwRead;

    // Elaboration-time parameter checks.
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_chk_latency
        $error("sdp_bram_pipe: READ_LATENCY must be in 1..4");
    end
    if (COL_WIDTH == 0 || (RAM_WIDTH % COL_WIDTH) != 0) begin : g_chk_width
        $error("sdp_bram_pipe: RAM_WIDTH must be a non-zero multiple of COL_WIDTH");
    end
    if (RAM_DEPTH < 2) begin : g_chk_depth
        $error("sdp_bram_pipe: RAM_DEPTH must be at least 2");
    end
    if (RDW_MODE != RdwReadFirst && RDW_MODE != RdwWriteFirst) begin : g_chk_mode
        $error("sdp_bram_pipe: RDW_MODE must be READ_FIRST or WRITE_FIRST");
    end
    // File preload needs a simulation/synthesis init block that this build does
    // not carry; contents always start at zero.
    if (INIT_FILE != "") begin : g_chk_init
        $error("sdp_bram_pipe: INIT_FILE preload is not supported, leave it empty");
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH] = '{default: '0};

    logic                 rd_accept;
    logic                 collide;
    logic [RAM_WIDTH-1:0] old_word;
    logic [RAM_WIDTH-1:0] merged_word;

    assign rd_accept = enb & ~rstb;
    assign collide   = rd_accept & (|wea) & (addra == addrb);
    assign old_word  = mem[addrb];

    // Word as it will look after this cycle's write, used for WRITE_FIRST.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NB_COL; i++) begin
            if (wea[i]) begin
                merged_word[i*COL_WIDTH +: COL_WIDTH] = dina[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    // Writes ignore rstb. Out-of-range addresses (non power-of-two depth) are dropped.
    always_ff @(posedge clka) begin
        if (32'(addra) < RAM_DEPTH) begin
            for (int i = 0; i < NB_COL; i++) begin
                if (wea[i]) begin
                    mem[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: array output register
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0] rd_data_q;
    logic                 rd_valid_q;
    logic                 rd_collide_q;

    always_ff @(posedge clka) begin
        if (rstb) begin
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_collide_q <= 1'b0;
        end else begin
            rd_valid_q   <= enb;
            rd_collide_q <= collide;
            if (enb) begin
                rd_data_q <= (collide && RdwMode == RdwWrite) ? merged_word : old_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stages 2..READ_LATENCY
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0] pipe_data    [READ_LATENCY];
    logic                 pipe_valid   [READ_LATENCY];
    logic                 pipe_collide [READ_LATENCY];

    assign pipe_data[0]    = rd_data_q;
    assign pipe_valid[0]   = rd_valid_q;
    assign pipe_collide[0] = rd_collide_q;

    for (genvar s = 1; s < READ_LATENCY; s++) begin : g_stage
        sdp_rd_stage #(
            .WIDTH (RAM_WIDTH)
        ) u_stage (
            .clka      (clka),
            .rstb      (rstb),
            .data_i    (pipe_data[s-1]),
            .valid_i   (pipe_valid[s-1]),
            .collide_i (pipe_collide[s-1]),
            .data_o    (pipe_data[s]),
            .valid_o   (pipe_valid[s]),
            .collide_o (pipe_collide[s])
        );
    end

    assign doutb         = pipe_data[READ_LATENCY-1];
    assign doutb_valid   = pipe_valid[READ_LATENCY-1];
    // Collide is only ever set alongside valid; the gate keeps that explicit.
    assign doutb_collide = pipe_valid[READ_LATENCY-1] & pipe_collide[READ_LATENCY-1];

endmodule
